// File: rtl/cmd_sequencer.sv
// Buffers up to DEPTH 16-bit commands and plays them to RemoteComm one at a time.
// Each command must be acknowledged with POS_ACK before the next one is sent.
module cmd_sequencer #(
  parameter int          DEPTH   = 16,
  parameter int          TIMEOUT = 2_000_000,
  parameter logic [7:0]  POS_ACK = 8'hA5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic [15:0]                load_data,
  input  logic                       start,
  input  logic                       clr,
  output logic [15:0]                cmd,
  output logic                       send_cmd,
  input  logic                       cmd_sent,
  input  logic                       resp_rdy,
  input  logic [7:0]                 resp,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [1:0]                 err_code,
  output logic [$clog2(DEPTH)-1:0]   err_idx,
  output logic [$clog2(DEPTH):0]     fill,
  output logic                       full
);

  localparam int IW = $clog2(DEPTH);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX    = TW'(TIMEOUT - 1);
  localparam logic [IW:0]   DEPTH_F = (IW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_SENT,
    S_WAIT_RESP,
    S_DONE,
    S_ERR
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     mem_q [DEPTH];
  logic [IW:0]     fill_q, fill_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic [15:0]     cmd_q, cmd_d;
  logic [1:0]      err_code_q, err_code_d;
  logic [IW-1:0]   err_idx_q, err_idx_d;
  logic            send_q, busy_q, done_q, err_q;
  logic            wr_en;
  logic            full_w;
  logic            last_w;
  logic [IW-1:0]   idx_nxt;

  assign full_w  = (fill_q == DEPTH_F);
  assign last_w  = ({1'b0, idx_q} == (fill_q - (IW + 1)'(1)));
  assign idx_nxt = idx_q + IW'(1);

  always_comb begin
    state_d    = state_q;
    fill_d     = fill_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    cmd_d      = cmd_q;
    err_code_d = err_code_q;
    err_idx_d  = err_idx_q;
    wr_en      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (load && !full_w) begin
          wr_en  = 1'b1;
          fill_d = fill_q + (IW + 1)'(1);
        end
        if (start) begin
          if (fill_d != '0) begin
            idx_d   = '0;
            state_d = S_SEND;
            // A word loaded in the same cycle into slot 0 is not in mem_q yet.
            cmd_d   = (wr_en && (fill_q == '0)) ? load_data : mem_q[0];
          end else begin
            state_d = S_DONE;
          end
        end
      end

      S_SEND: begin
        state_d = S_WAIT_SENT;
      end

      S_WAIT_SENT: begin
        if (cmd_sent) begin
          cnt_d   = '0;
          state_d = S_WAIT_RESP;
        end
      end

      S_WAIT_RESP: begin
        if (cnt_q != TMAX) begin
          cnt_d = cnt_q + TW'(1);
        end
        if (resp_rdy) begin
          if (resp == POS_ACK) begin
            if (last_w) begin
              state_d = S_DONE;
            end else begin
              idx_d   = idx_nxt;
              cmd_d   = mem_q[idx_nxt];
              state_d = S_SEND;
            end
          end else begin
            err_code_d = 2'b01;
            err_idx_d  = idx_q;
            state_d    = S_ERR;
          end
        end else if (cnt_q == TMAX) begin
          err_code_d = 2'b10;
          err_idx_d  = idx_q;
          state_d    = S_ERR;
        end
      end

      S_DONE, S_ERR: begin
        if (clr) begin
          state_d    = S_IDLE;
          fill_d     = '0;
          err_code_d = 2'b00;
          err_idx_d  = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      fill_q     <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      cmd_q      <= '0;
      err_code_q <= 2'b00;
      err_idx_q  <= '0;
      send_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_q     <= fill_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
      err_code_q <= err_code_d;
      err_idx_q  <= err_idx_d;
      // Status outputs are registered decodes of the upcoming state.
      send_q     <= (state_d == S_SEND);
      busy_q     <= (state_d == S_SEND) || (state_d == S_WAIT_SENT) ||
                    (state_d == S_WAIT_RESP);
      done_q     <= (state_d == S_DONE);
      err_q      <= (state_d == S_ERR);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[fill_q[IW-1:0]] <= load_data;
    end
  end

  assign cmd      = cmd_q;
  assign send_cmd = send_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign err_code = err_code_q;
  assign err_idx  = err_idx_q;
  assign fill     = fill_q;
  assign full     = full_w;

endmodule

// File: doc/cmd_sequencer.md
# cmd_sequencer

Synthesizable command-script player that sits directly upstream of the RemoteComm bluetooth model. It buffers a list of 16-bit MazeRunner commands, then plays them out one at a time over RemoteComm's `send_cmd`/`cmd_sent`/`resp_rdy` handshake. After each command it checks for the 0xA5 positive acknowledge and stops on a bad response or a timeout. It lets full-chip benches (and an FPGA demo harness) run a maze script without hand-sequenced stimulus.

## Interface
Parameters:
- `DEPTH`, 16: command buffer entries (power of 2, 2..256).
- `TIMEOUT`, 2_000_000: clk cycles allowed in WAIT_RESP before a timeout error.
- `POS_ACK`, 8'hA5: the only response byte accepted as a pass.

Ports:
- `clk`, in, 1: system clock. One clock domain.
- `rst`, in, 1: reset, synchronous and active-high.
- `load`, in, 1: write `load_data` into the buffer this cycle.
- `load_data`, in, 16: command word to buffer.
- `start`, in, 1: begin playback of the buffered commands.
- `clr`, in, 1: return from DONE/ERR to IDLE and empty the buffer.
- `cmd`, out, 16: command presented to RemoteComm.
- `send_cmd`, out, 1: one-cycle strobe to RemoteComm.
- `cmd_sent`, in, 1: RemoteComm finished transmitting both bytes.
- `resp_rdy`, in, 1: RemoteComm received a response byte.
- `resp`, in, 8: the response byte.
- `busy`, out, 1: asserted in SEND, WAIT_SENT and WAIT_RESP.
- `done`, out, 1: all commands acknowledged; held until `clr` or `rst`.
- `err`, out, 1: playback aborted; held until `clr` or `rst`.
- `err_code`, out, 2: 01 = bad response, 10 = timeout, 00 = no error.
- `err_idx`, out, log2(DEPTH): buffer index of the failing command.
- `fill`, out, log2(DEPTH)+1: number of buffered commands.
- `full`, out, 1: `fill == DEPTH`.

## Operation
- States: IDLE, SEND, WAIT_SENT, WAIT_RESP, DONE, ERR.
- IDLE
  - `load` with `!full` writes `load_data` at index `fill` and increments `fill`.
  - `load` when `full` is ignored; buffer and `fill` are unchanged.
  - `start` with `fill != 0` clears the play index `idx` to 0 and goes to SEND.
  - `start` with `fill == 0` goes directly to DONE.
  - `load` and `start` in the same cycle: both are accepted, and the loaded word is part of the script.
- SEND: `cmd <= buf[idx]`, `send_cmd = 1` for exactly this cycle, then go to WAIT_SENT.
- WAIT_SENT: wait for `cmd_sent`, then go to WAIT_RESP with the timeout counter cleared. `resp_rdy` is ignored in this state.
- WAIT_RESP
  - Timeout counter increments every cycle.
  - `resp_rdy` with `resp == POS_ACK`:
    - if `idx == fill-1`, go to DONE;
    - otherwise increment `idx` and go to SEND.
  - `resp_rdy` with any other `resp`: `err_code = 01`, `err_idx = idx`, go to ERR.
  - Counter reaches `TIMEOUT-1` with no `resp_rdy`: `err_code = 10`, `err_idx = idx`, go to ERR.
  - `resp_rdy` on the expiry cycle: the response wins and the timeout is not flagged.
- DONE / ERR
  - `load` and `start` are ignored.
  - `clr` goes to IDLE, sets `fill = 0`, `err_code = 0`, `err_idx = 0`.
- Outside IDLE:
  - `load` and `start` are ignored.
  - `clr` is ignored except in DONE/ERR.
- `cmd` holds its last value between commands. It only changes on entry to SEND.
- Arithmetic:
  - `idx` and `err_idx` are log2(DEPTH) bits; `idx` never wraps, because playback stops at `fill-1`.
  - `fill` is one bit wider than the index, so it can represent the full condition.
  - The timeout counter is `$clog2(TIMEOUT)` bits and saturates; it does not wrap.

## Timing
- Reset values:
  - state = IDLE;
  - `cmd`, `fill`, `idx`, `err_code`, `err_idx`, timeout counter = 0;
  - `send_cmd`, `busy`, `done`, `err` = 0;
  - `full` = 0.
  - Buffer contents are don't-care.
- `rst` mid-playback drops `send_cmd` and returns all outputs to their reset values on the next edge. Buffered commands are discarded.
- `start` sampled high at edge N puts the design in SEND during cycle N+1, so `send_cmd` is high in cycle N+1 with `cmd` valid.
- `cmd_sent` sampled at edge M puts the design in WAIT_RESP from cycle M+1.
- A passing `resp_rdy` at edge R (not the last command) puts the design in SEND in cycle R+1, with the next `send_cmd` in cycle R+1.
- `done` and `err` rise one cycle after the deciding edge and are level outputs.
- `busy` is a registered decode of the state.
- `send_cmd` is never high two consecutive cycles.

## Test plan
- Load 0x2000, 0x4002, 0x6000, start; RemoteComm returns 0xA5 for each -> exactly three `send_cmd` pulses, `cmd` = 0x2000, 0x4002, 0x6000 in order; `done` = 1, `err` = 0.
- Load two commands; the second response is 0x5A -> `err` = 1, `err_code` = 01, `err_idx` = 1, no third `send_cmd`; `clr` -> IDLE, `fill` = 0.
- TIMEOUT = 100, responder silent after `cmd_sent` -> `err_code` = 10 exactly 100 cycles after entering WAIT_RESP; a `resp_rdy` on cycle 100 instead -> no error.
- Load 17 words with DEPTH = 16 -> `full` = 1, `fill` = 16, the 17th word is dropped; playback sends only the first 16.
- `start` with an empty buffer -> `done` = 1 on the next cycle, no `send_cmd`; `load` and `start` in the same cycle -> one command sent.
- Assert `rst` while in WAIT_SENT -> next cycle `busy` = 0, `fill` = 0, `cmd` = 0; later `cmd_sent`/`resp_rdy` pulses cause no state change.
